cm0ik_misc_delay_chk: RTL and testbench

Loopback stimulus-and-check block for the fclk signal delay line in the Miscellaneous logic block. On request it launches a single-cycle pulse into the delay line's input, watches the delay line's output, and reports the measured latency in fclk cycles, the pulse width integrity and a pass/fail verdict. It sits beside the delay line in the Integration Kit test logic: `tx_o` drives the delay input and `ret_i` takes the delay output.

---
 rtl/cm0ik_misc_delay_chk.sv | 111 +++++++++++
 tb/tb_cm0ik_misc_delay_chk.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cm0ik_misc_delay_chk.sv
// Loopback checker for the fclk delay line: launches a one-cycle pulse, times
// its return in fclk cycles and flags latency, width and timeout results.
module cm0ik_misc_delay_chk #(
  parameter int unsigned EXP_DELAY = 24,
  parameter int unsigned MAX_WAIT  = 63,
  parameter int unsigned CW        = 6
) (
  input  logic          fclk,
  input  logic          hresetn,
  input  logic          start,
  input  logic          ret_i,
  output logic          tx_o,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic          width_err,
  output logic [CW-1:0] measured
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WIDTH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            tx_nxt, busy_nxt, done_nxt, pass_nxt, timeout_nxt, width_err_nxt;
  logic [CW-1:0]   measured_nxt;

  // State, counter and all outputs registered together
  always_ff @(posedge fclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tx_o      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      width_err <= 1'b0;
      measured  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tx_o      <= tx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      timeout   <= timeout_nxt;
      width_err <= width_err_nxt;
      measured  <= measured_nxt;
    end
  end

  // Next-state and next-output decode; tx and done are single-cycle by default
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    tx_nxt        = 1'b0;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    pass_nxt      = pass;
    timeout_nxt   = timeout;
    width_err_nxt = width_err;
    measured_nxt  = measured;

    case (state)
      ST_IDLE: begin
        if (start) begin
          tx_nxt        = 1'b1;
          busy_nxt      = 1'b1;
          cnt_nxt       = '0;
          pass_nxt      = 1'b0;
          timeout_nxt   = 1'b0;
          width_err_nxt = 1'b0;
          measured_nxt  = '0;
          state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ret_i) begin
          measured_nxt = cnt;
          state_nxt    = ST_WIDTH;
        end else if (cnt == CW'(MAX_WAIT)) begin
          timeout_nxt  = 1'b1;
          measured_nxt = CW'(MAX_WAIT);
          pass_nxt     = 1'b0;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_WIDTH: begin
        // A return still high one cycle after arrival is a stretched pulse
        width_err_nxt = ret_i;
        pass_nxt      = (measured == CW'(EXP_DELAY)) & ~ret_i;
        done_nxt      = 1'b1;
        busy_nxt      = 1'b0;
        state_nxt     = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cm0ik_misc_delay_chk.sv
// Bench for cm0ik_misc_delay_chk: a tx-driven delay-line model feeds ret_i and
// each result is compared with a latency model derived from the return pattern.
module tb_cm0ik_misc_delay_chk;

  localparam int EXP_DELAY = 24;
  localparam int MAX_WAIT  = 63;
  localparam int CW        = 6;

  logic          fclk = 1'b0;
  logic          hresetn;
  logic          start;
  logic          ret_i;
  logic          tx_o, busy, done, pass, timeout, width_err;
  logic [CW-1:0] measured;

  int errors = 0;
  int checks = 0;

  // Delay-line model: 0 ideal, 1 stretched to two cycles, 2 tied low, 3 stuck high
  int           mode = 2;
  int           dl   = 24;
  logic [127:0] hist;

  cm0ik_misc_delay_chk #(
    .EXP_DELAY (EXP_DELAY),
    .MAX_WAIT  (MAX_WAIT),
    .CW        (CW)
  ) dut (
    .fclk      (fclk),
    .hresetn   (hresetn),
    .start     (start),
    .ret_i     (ret_i),
    .tx_o      (tx_o),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .width_err (width_err),
    .measured  (measured)
  );

  always #5 fclk = ~fclk;

  always @(posedge fclk or negedge hresetn) begin
    if (!hresetn) hist <= '0;
    else          hist <= {hist[126:0], tx_o};
  end

  always_comb begin
    ret_i = 1'b0;
    case (mode)
      0:       ret_i = hist[7'(dl - 1)];
      1:       ret_i = hist[7'(dl - 1)] | hist[7'(dl)];
      3:       ret_i = 1'b1;
      default: ret_i = 1'b0;
    endcase
  end

  // Return level seen t edges after the launch edge S, sampled at edge S+t+1
  function automatic bit ret_model(input int m, input int d, input int t);
    case (m)
      0:       return (t == d);
      1:       return (t == d) || (t == d + 1);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected result: first sampled arrival gives latency, the next sample width
  task automatic model(input int m, input int d, output int e_meas, output int e_lat,
                       output bit e_pass, output bit e_to, output bit e_w);
    e_meas = MAX_WAIT; e_lat = MAX_WAIT + 1; e_pass = 0; e_to = 1; e_w = 0;
    for (int k = 0; k <= MAX_WAIT; k++) begin
      if (ret_model(m, d, k)) begin
        e_meas = k;
        e_lat  = k + 2;
        e_to   = 0;
        e_w    = ret_model(m, d, k + 1);
        e_pass = (k == EXP_DELAY) && !e_w;
        break;
      end
    end
  endtask

  // Idle gap, launch, then watch edges until done; inj_a/inj_b re-pulse start while busy
  task automatic do_run(input int inj_a, input int inj_b,
                        output logic tx0, output logic busy0, output logic tx1,
                        output int lat, output logic busy_ok, output logic busy_d,
                        output logic done2);
    repeat (50) @(posedge fclk);
    #1 start = 1'b1;
    @(posedge fclk);
    #1 start = 1'b0;
    tx0 = tx_o; busy0 = busy;
    lat = -1; busy_ok = 1'b1; tx1 = 1'bx; busy_d = 1'bx;
    for (int n = 1; n <= 80; n++) begin
      start = (n == inj_a) || (n == inj_b);
      @(posedge fclk);
      #1 start = 1'b0;
      if (n == 1) tx1 = tx_o;
      if (done) begin
        lat = n; busy_d = busy;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    @(posedge fclk);
    #1 done2 = done;
  endtask

  task automatic test_measure(input string name, input int m, input int d);
    logic tx0, busy0, tx1, busy_ok, busy_d, done2;
    int   lat, e_meas, e_lat;
    bit   e_pass, e_to, e_w;
    mode = m; dl = d;
    model(m, d, e_meas, e_lat, e_pass, e_to, e_w);
    do_run(-1, -1, tx0, busy0, tx1, lat, busy_ok, busy_d, done2);
    checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL %s tx_launch: got %b want 1", name, tx0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL %s busy_launch: got %b want 1", name, busy0); end
    checks++; if (tx1 !== 1'b0)   begin errors++; $display("FAIL %s tx_width: got %b want 0", name, tx1); end
    checks++; if (lat !== e_lat)  begin errors++; $display("FAIL %s done_latency: got %0d want %0d", name, lat, e_lat); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL %s busy_held: got %b want 1", name, busy_ok); end
    checks++; if (busy_d !== 1'b0)  begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy_d); end
    checks++; if (done2 !== 1'b0)   begin errors++; $display("FAIL %s done_one_cycle: got %b want 0", name, done2); end
    checks++; if (measured !== CW'(e_meas)) begin errors++; $display("FAIL %s measured: got %0d want %0d", name, measured, e_meas); end
    checks++; if (pass !== e_pass)      begin errors++; $display("FAIL %s pass: got %b want %b", name, pass, e_pass); end
    checks++; if (timeout !== e_to)     begin errors++; $display("FAIL %s timeout: got %b want %b", name, timeout, e_to); end
    checks++; if (width_err !== e_w)    begin errors++; $display("FAIL %s width_err: got %b want %b", name, width_err, e_w); end
  endtask

  task automatic test_reset();
    logic [CW+5:0] outs;
    hresetn = 1'b0; start = 1'b0; mode = 3;
    repeat (2) @(posedge fclk);
    #1 start = 1'b1;
    repeat (2) @(posedge fclk);
    #1 outs = {tx_o, busy, done, pass, timeout, width_err, measured};
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset outputs: got %h want 0", outs); end
    start = 1'b0; hresetn = 1'b1;
    @(posedge fclk);
    #1 outs = {tx_o, busy, done, pass, timeout, width_err, measured};
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset idle_after_release: got %h want 0", outs); end
  endtask

  task automatic test_busy_ignore();
    logic tx0, busy0, tx1, busy_ok, busy_d, done2;
    int   lat, extra;
    mode = 0; dl = EXP_DELAY;
    do_run(5, 10, tx0, busy0, tx1, lat, busy_ok, busy_d, done2);
    extra = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge fclk);
      #1 if (done || tx_o) extra++;
    end
    checks++; if (lat !== 26)   begin errors++; $display("FAIL busy_ignore done_latency: got %0d want 26", lat); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL busy_ignore busy_held: got %b want 1", busy_ok); end
    checks++; if (done2 !== 1'b0 || extra !== 0) begin errors++; $display("FAIL busy_ignore extra_activity: got %0d want 0", extra + int'(done2)); end
    checks++; if (pass !== 1'b1 || measured !== CW'(24)) begin errors++; $display("FAIL busy_ignore result: got pass=%b meas=%0d want pass=1 meas=24", pass, measured); end
  endtask

  task automatic test_reset_abort();
    logic [CW+5:0] outs;
    int stray;
    mode = 0; dl = EXP_DELAY;
    repeat (50) @(posedge fclk);
    #1 start = 1'b1;
    @(posedge fclk);
    #1 start = 1'b0;
    repeat (11) @(posedge fclk);
    #1 hresetn = 1'b0;
    #1 outs = {tx_o, busy, done, pass, timeout, width_err, measured};
    checks++; if (outs !== '0) begin errors++; $display("FAIL abort outputs_in_reset: got %h want 0", outs); end
    repeat (2) @(posedge fclk);
    #1 outs = {tx_o, busy, done, pass, timeout, width_err, measured};
    checks++; if (outs !== '0) begin errors++; $display("FAIL abort outputs_held: got %h want 0", outs); end
    hresetn = 1'b1;
    stray = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge fclk);
      #1 if (done || busy) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL abort stray_done: got %0d want 0", stray); end
    test_measure("after_abort", 0, EXP_DELAY);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic tx_s, done_s;
    mode = 0; dl = EXP_DELAY;
    repeat (50) @(posedge fclk);
    #1 start = 1'b1;
    @(posedge fclk);
    #1 start = 1'b0;
    lat1 = -1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge fclk);
      #1 if (done) begin lat1 = n; break; end
    end
    start = 1'b1;
    @(posedge fclk);
    #1 start = 1'b0;
    tx_s = tx_o; done_s = done;
    lat2 = -1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge fclk);
      #1 if (done) begin lat2 = n; break; end
    end
    checks++; if (lat1 !== 26) begin errors++; $display("FAIL b2b first_latency: got %0d want 26", lat1); end
    checks++; if (tx_s !== 1'b1 || done_s !== 1'b0) begin errors++; $display("FAIL b2b relaunch: got tx=%b done=%b want tx=1 done=0", tx_s, done_s); end
    checks++; if (lat2 !== 26) begin errors++; $display("FAIL b2b second_latency: got %0d want 26", lat2); end
    checks++; if (measured !== CW'(24) || pass !== 1'b1) begin errors++; $display("FAIL b2b result: got meas=%0d pass=%b want 24/1", measured, pass); end
  endtask

  task automatic test_random();
    int m, d;
    for (int i = 0; i < 10; i++) begin
      m = int'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? EXP_DELAY : int'($urandom_range(1, 40));
      test_measure($sformatf("rand%0d_m%0d_d%0d", i, m, d), m, d);
    end
  endtask

  initial begin
    hresetn = 1'b0;
    start   = 1'b0;
    test_reset();
    test_measure("ideal24", 0, 24);
    test_measure("short20", 0, 20);
    test_measure("tied0", 2, 24);
    test_measure("stretch24", 1, 24);
    test_measure("stuck1", 3, 24);
    test_measure("min1", 0, 1);
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
